// File: rtl/wm_pkg.sv
// Shared types and constants for the whack-a-mole sequencer.
// Used by wm_lfsr16 and wm_mole_sequencer (optional feature macro: WM_NO_REPEAT_EN).
package wm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int unsigned NUM_MOLES = 4;

    // Button mask that exactly matches a mole index.
    function automatic logic [NUM_MOLES-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_MOLES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wm_lfsr16.sv
// 16-bit Galois LFSR, free-running every cycle; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module wm_lfsr16
    import wm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_eff;

    always_comb begin
        seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
        q_d      = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed_eff;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/wm_mole_sequencer.sv
// Whack-a-mole game sequencer: picks moles, times GAP/SHOW windows, scores presses.
// Define WM_NO_REPEAT_EN to force consecutive moles to differ.
module wm_mole_sequencer
    import wm_pkg::*;
#(
    parameter int unsigned TICKS_ON  = 50_000_000,
    parameter int unsigned TICKS_OFF = 12_500_000,
    parameter int unsigned ROUNDS    = 16,
    parameter int unsigned SCORE_W   = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         btn,
    output logic [1:0]         rn,
    output logic               enable,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TICKS_MAX = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
    localparam int unsigned TIMER_W   = $clog2(TICKS_MAX);
    localparam int unsigned ROUND_W   = $clog2(ROUNDS + 1);

    localparam logic [TIMER_W-1:0] LAST_OFF = TIMER_W'(TICKS_OFF - 1);
    localparam logic [TIMER_W-1:0] LAST_ON  = TIMER_W'(TICKS_ON - 1);
    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(ROUNDS);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [1:0]           rn_q, rn_d;
    logic                 enable_q, enable_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [3:0]           btn_q, btn_d;

    logic [15:0]          lfsr;
    logic [3:0]           rise;
    logic [3:0]           target;
    logic [1:0]           next_rn;
    logic [ROUND_W-1:0]   round_inc;
    logic                 resolve;
    logic                 unused_lfsr_bits;

    wm_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // Only the low two bits select a mole; the rest just feed the sequence.
    assign unused_lfsr_bits = ^lfsr[15:2];

    // Mole selection, with optional anti-repeat bump.
    always_comb begin
`ifdef WM_NO_REPEAT_EN
        next_rn = (lfsr[1:0] == rn_q) ? (rn_q + 2'd1) : lfsr[1:0];
`else
        next_rn = lfsr[1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            round_q  <= '0;
            rn_q     <= '0;
            enable_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            btn_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            round_q  <= round_d;
            rn_q     <= rn_d;
            enable_q <= enable_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            btn_q    <= btn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        round_d   = round_q;
        rn_d      = rn_q;
        enable_d  = enable_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        score_d   = score_q;
        busy_d    = busy_q;
        done_d    = done_q;
        btn_d     = btn;
        rise      = btn & ~btn_q;
        target    = onehot4(rn_q);
        round_inc = round_q + ROUND_W'(1);
        resolve   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = GAP;
                    score_d  = '0;
                    round_d  = '0;
                    timer_d  = '0;
                    enable_d = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end

            GAP: begin
                enable_d = 1'b0;
                busy_d   = 1'b1;
                if (timer_q == LAST_OFF) begin
                    timer_d  = '0;
                    rn_d     = next_rn;
                    enable_d = 1'b1;
                    state_d  = SHOW;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            SHOW: begin
                // Exact hit outranks a wrong press, which outranks timeout.
                if (rise == target) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    resolve = 1'b1;
                end else if (rise != 4'b0000) begin
                    miss_d  = 1'b1;
                    resolve = 1'b1;
                end else if (timer_q == LAST_ON) begin
                    miss_d  = 1'b1;
                    resolve = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end

                if (resolve) begin
                    round_d  = round_inc;
                    enable_d = 1'b0;
                    timer_d  = '0;
                    if (round_inc == LAST_RND) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rn         = rn_q;
    assign enable     = enable_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_wm_mole_sequencer.sv
// Scoreboard bench for wm_mole_sequencer with short windows (ON=8, OFF=4, 3 rounds).
// Build with WM_NO_REPEAT_EN to exercise the anti-repeat variant.
module tb_wm_mole_sequencer;

    localparam int unsigned TON  = 8;
    localparam int unsigned TOFF = 4;
    localparam int unsigned RNDS = 3;
    localparam int unsigned SW   = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_HIT     = 0;
    localparam int M_DOUBLE  = 1;
    localparam int M_TIMEOUT = 2;
    localparam int M_HOLD    = 3;

    typedef struct packed {
        logic       hit;
        logic [7:0] score;
        logic [7:0] lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    btn;
    logic [1:0]    rn;
    logic          enable;
    logic          hit_pulse;
    logic          miss_pulse;
    logic [SW-1:0] score;
    logic          busy;
    logic          done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_score = 0;
    exp_t sb[$];

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_hist;
    logic        rst_seen;
    logic        en_prev = 1'b0;
    int          show_cnt = 0;
    int          gap_cnt = 0;
    logic [1:0]  prev_rn_m = 2'd0;
    logic [1:0]  last_rn = 2'd0;
    int          repeats = 0;
    int          moles = 0;

    wm_mole_sequencer #(
        .TICKS_ON  (TON),
        .TICKS_OFF (TOFF),
        .ROUNDS    (RNDS),
        .SCORE_W   (SW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .btn        (btn),
        .rn         (rn),
        .enable     (enable),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR; lfsr_hist holds the value seen during the previous cycle.
    always @(posedge clk) begin
        lfsr_hist <= lfsr_m;
        rst_seen  <= reset;
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= m_step(lfsr_m);
    end

    // Monitor: mole selection, GAP length, and pulses against the scoreboard.
    always @(negedge clk) begin
        logic [1:0] exp_rn;
        exp_t       it;
        if (rst_seen) begin
            en_prev   = 1'b0;
            show_cnt  = 0;
            gap_cnt   = 0;
            prev_rn_m = 2'd0;
            last_rn   = 2'd0;
        end else begin
            if (enable && !en_prev) begin
                exp_rn = lfsr_hist[1:0];
`ifdef WM_NO_REPEAT_EN
                if (exp_rn == prev_rn_m) exp_rn = exp_rn + 2'd1;
`endif
                check_eq("rn", 32'(rn), 32'(exp_rn));
                check_eq("gap_len", 32'(gap_cnt), 32'(TOFF));
                prev_rn_m = exp_rn;
                if (rn == last_rn) repeats++;
                last_rn  = rn;
                moles++;
                show_cnt = 0;
            end else begin
                show_cnt++;
            end
            if (busy && !enable) gap_cnt++;
            else                 gap_cnt = 0;

            if (hit_pulse || miss_pulse) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_pulse", 32'(hit_pulse), 32'(miss_pulse));
                    check_eq("pulse_without_stimulus", 32'd1, 32'(sb.size()));
                end else begin
                    it = sb.pop_front();
                    check_eq("pulse_kind_hit", 32'(hit_pulse), 32'(it.hit));
                    check_eq("pulse_kind_miss", 32'(miss_pulse), 32'(!it.hit));
                    check_eq("score_at_pulse", 32'(score), 32'(it.score));
                    check_eq("pulse_latency", 32'(show_cnt), 32'(it.lat));
                    check_eq("enable_off_at_pulse", 32'(enable), 32'd0);
                end
            end
            en_prev = enable;
        end
    end

    task automatic wait_show();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (enable !== 1'b1 && n < 100);
        if (enable !== 1'b1) check_eq("wait_show_timeout", 32'(enable), 32'd1);
    endtask

    task automatic wait_dark();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (enable !== 1'b0 && n < 100);
        if (enable !== 1'b0) check_eq("wait_dark_timeout", 32'(enable), 32'd0);
    endtask

    // start held a few cycles into GAP to show it is ignored there.
    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        exp_score = 0;
        @(negedge clk);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("done_after_start", 32'(done), 32'd0);
        check_eq("score_after_start", 32'(score), 32'd0);
        repeat (2) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic play_mole(input int mode, input int k);
        logic [3:0] b;
        exp_t       e;
        wait_show();
        if (mode == M_TIMEOUT) begin
            e = '{hit: 1'b0, score: 8'(exp_score), lat: 8'(TON)};
            sb.push_back(e);
        end else if (mode == M_HOLD) begin
            repeat (2) @(negedge clk);
            btn = 4'b0000;
            repeat (2) @(negedge clk);
            exp_score++;
            e = '{hit: 1'b1, score: 8'(exp_score), lat: 8'd5};
            sb.push_back(e);
            btn = 4'b0001 << rn;
            @(negedge clk);
            btn = 4'b0000;
        end else begin
            repeat (k) @(negedge clk);
            b = 4'b0001 << rn;
            if (mode == M_DOUBLE) b = b | (4'b0001 << 2'(rn + 2'd1));
            if (mode == M_HIT) exp_score++;
            e = '{hit: (mode == M_HIT), score: 8'(exp_score), lat: 8'(k + 1)};
            sb.push_back(e);
            btn = b;
            @(negedge clk);
            btn = 4'b0000;
        end
        wait_dark();
    endtask

    task automatic wait_done(input int want_score);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        check_eq("done", 32'(done), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("enable_at_done", 32'(enable), 32'd0);
        check_eq("final_score", 32'(score), 32'(want_score));
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("rst_rn", 32'(rn), 32'd0);
        check_eq("rst_enable", 32'(enable), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_enable", 32'(enable), 32'd0);

        // All correct presses, two cycles into each window.
        start_game();
        for (int i = 0; i < int'(RNDS); i++) play_mole(M_HIT, 2);
        wait_done(3);

        // No presses: every mole times out.
        start_game();
        for (int i = 0; i < int'(RNDS); i++) play_mole(M_TIMEOUT, 0);
        wait_done(0);

        // Double press counts as a miss; then a hit; then a timeout.
        start_game();
        play_mole(M_DOUBLE, 2);
        play_mole(M_HIT, 2);
        play_mole(M_TIMEOUT, 0);
        wait_done(1);

        // Buttons held across GAP->SHOW never score until released and repressed.
        start_game();
        btn = 4'b1111;
        play_mole(M_HOLD, 0);
        play_mole(M_TIMEOUT, 0);
        play_mole(M_TIMEOUT, 0);
        wait_done(1);

        // Reset in the middle of SHOW aborts the game.
        start_game();
        wait_show();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_rn", 32'(rn), 32'd0);
        check_eq("midrst_enable", 32'(enable), 32'd0);
        check_eq("midrst_hit", 32'(hit_pulse), 32'd0);
        check_eq("midrst_miss", 32'(miss_pulse), 32'd0);
        check_eq("midrst_score", 32'(score), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_idle_busy", 32'(busy), 32'd0);
        start_game();
        for (int i = 0; i < int'(RNDS); i++) play_mole(M_HIT, 2);
        wait_done(3);

        // Long run of quick hits to observe mole repetition behaviour.
        while (moles < 1000) begin
            start_game();
            for (int i = 0; i < int'(RNDS); i++) play_mole(M_HIT, 0);
            wait_done(3);
        end
`ifdef WM_NO_REPEAT_EN
        check_eq("consecutive_repeats", 32'(repeats), 32'd0);
`else
        check_eq("repeats_occur", 32'(repeats > 0), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
